datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Controller that sequences the 8-bit register-file/ALU datapath. Accepts 22-bit instruction words over a valid/ready handshake into a small FIFO, decodes each one and drives the datapath control lines: write enable, input-data mux select, destination, A/B source and ALU operation. A two-phase issue scheme (setup, then write) keeps every select stable for a full cycle before the gated write enable rises. The sequencer also provides a HALT/resume mechanism.

## Interface
- `FIFO_DEPTH`, default 4: instruction FIFO entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: instruction word offered.
- `in_ready` output 1: FIFO can accept; equals !full.
- `in_instr` input 22: instruction word; fields below.
- `resume` input 1: leave HALTED state.
- `write_enable` output 1: datapath register-file write.
- `mux_sel` output 1: 1 selects `input_data`, 0 selects the ALU result.
- `input_data` output 8: immediate for LOAD.
- `dst_sel` output 4: destination register.
- `a_sel` output 4: A-port register.
- `b_sel` output 4: B-port register.
- `op_sel` output 4: ALU operation.
- `busy` output 1: FSM not IDLE, or FIFO not empty.
- `halted` output 1: FSM in HALTED.
- `retire` output 1: one-cycle pulse per retired instruction.

## Operation
- Fields: `kind`=[21:20], `dst`=[19:16]. ALU uses `A`=[15:12], `B`=[11:8], `op`=[7:4]. LOAD uses `imm`=[7:0].
- Kinds: 00 NOP, 01 LOAD, 10 ALU, 11 HALT.
- Push occurs when `in_valid & in_ready`. Pop occurs on the IDLE→SETUP, IDLE→HALTED and IDLE→retire-NOP transitions.
- FSM states: IDLE, SETUP, WRITE, HALTED.
- IDLE with FIFO empty: stay in IDLE.
- IDLE with FIFO head present:
  - LOAD/ALU: pop, latch fields into output registers, go to SETUP.
  - NOP: pop, pulse `retire`, stay in IDLE.
  - HALT: pop, go to HALTED.
- SETUP: selects stable, `write_enable`=0. Go to WRITE.
- WRITE: `write_enable`=1, selects unchanged. Pulse `retire`, go to IDLE.
- HALTED: `retire` pulses on entry. Stay until `resume`=1, then go to IDLE. `resume` is ignored in every other state.
- LOAD drives `mux_sel`=1 and `input_data`=imm. `a_sel`, `b_sel` and `op_sel` keep their previous values.
- ALU drives `mux_sel`=0, `a_sel`/`b_sel`/`op_sel` from the fields, and `input_data` keeps its previous value.
- `dst_sel` is driven from the instruction for both LOAD and ALU.
- Select outputs change only on IDLE→SETUP. They are never modified in SETUP or WRITE.
- FIFO full: `in_ready`=0 and `in_valid` is ignored.
- Push and pop in the same cycle on a full FIFO:
  - `in_ready` still reflects full, so no push occurs.
  - The pop frees one entry; `in_ready` rises the next cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: both occur and the count is unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is held in log2(`FIFO_DEPTH`)+1 bits.

## Timing
- Reset (synchronous, wins over all other inputs): FSM goes to IDLE and the FIFO empties.
- Output values after reset: `write_enable`=0, `mux_sel`=0, `input_data`=0, all selects=0, `busy`=0, `halted`=0, `retire`=0, and `in_ready`=1 on the first cycle after reset.
- Reset mid-WRITE: `write_enable` is 0 in the cycle after the reset edge. The in-flight and queued instructions are discarded.
- All outputs except `in_ready` are registered.
- Latency, push to `write_enable` high, with an empty FIFO and the FSM in IDLE: 3 cycles. Push at edge 0, pop/SETUP at edge 1, WRITE at edge 2, observed in cycle 2.
- Sustained throughput: one LOAD/ALU every 3 cycles (IDLE, SETUP, WRITE).
- NOP costs 1 cycle. HALT costs 1 cycle plus the wait for `resume`.

## Configuration
- `DP_SEQ_BACK2BACK_EN`
- Defined: WRITE may go directly to SETUP when the FIFO head is LOAD/ALU, popping and latching in the same cycle. Throughput becomes one write per 2 cycles.
- Undefined: WRITE always returns to IDLE, exactly as described above.

## Structure
- Package `dp_seq_pkg`:
  - kind constants `KIND_NOP`, `KIND_LOAD`, `KIND_ALU`, `KIND_HALT`;
  - state enum `dp_seq_state_t`;
  - field bit-position constants;
  - `INSTR_W`=22.
- Sub-module `dp_seq_fifo`: parameterised synchronous FIFO with push, pop, full, empty and head outputs.
- Decode and FSM live in the top module.

## Test plan
- After reset, push LOAD dst=3 imm=0xA5:
  - in the 3rd cycle `write_enable`=1, `mux_sel`=1, `dst_sel`=3, `input_data`=0xA5;
  - `retire` pulses the same cycle.
- Push ALU dst=2 A=3 B=4 op=5: `a_sel`=3, `b_sel`=4, `op_sel`=5, `mux_sel`=0 and `dst_sel`=2 are stable across SETUP and WRITE; `write_enable` is high for exactly 1 cycle.
- Hold `in_valid` with 5 LOADs and `FIFO_DEPTH`=4:
  - `in_ready` drops after the 4th accepted;
  - all 5 write in order with dst 0..4.
- Push HALT followed by LOAD dst=1: `halted`=1 and no write occurs until `resume`. The write follows 3 cycles after `resume`.
- Assert `rst` during WRITE of a queued sequence: `write_enable`=0 in the next cycle, `busy`=0, `in_ready`=1.
- NOP stream: `retire` pulses each cycle and `write_enable` never asserts. With `DP_SEQ_BACK2BACK_EN` defined, two LOADs write 2 cycles apart.

Source files
------------

// File: rtl/dp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp_seq_pkg
//  Description : Shared definitions for the datapath sequencer. Holds the
//                instruction word width, instruction-kind encodings, field
//                bit positions, the sequencer state type and a small decode
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dp_seq_pkg;

    localparam int INSTR_W = 22;

    // Instruction kinds, carried in the top two bits of the word
    localparam logic [1:0] KIND_NOP  = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_ALU  = 2'b10;
    localparam logic [1:0] KIND_HALT = 2'b11;

    // Field bit positions
    localparam int KIND_MSB = 21;
    localparam int KIND_LSB = 20;
    localparam int DST_MSB  = 19;
    localparam int DST_LSB  = 16;
    localparam int A_MSB    = 15;
    localparam int A_LSB    = 12;
    localparam int B_MSB    = 11;
    localparam int B_LSB    = 8;
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_HALTED = 2'd3
    } dp_seq_state_t;

    // True for the kinds that perform a register-file write
    function automatic logic is_write_kind(input logic [1:0] kind);
        return (kind == KIND_LOAD) || (kind == KIND_ALU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dp_seq_fifo
//  Description : Synchronous instruction FIFO. Push is ignored while full,
//                pop is ignored while empty. Pointers wrap modulo DEPTH,
//                which must be a power of two (>= 2).
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_push, i_data - write request and data
//                i_pop          - consume the head entry
//                o_full/o_empty - occupancy flags (from the count register)
//                o_head         - entry at the read pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_sequencer
//  Description : Sequences the 8-bit register-file/ALU datapath. Instructions
//                enter a FIFO over valid/ready, are decoded at the head and
//                issued in two phases: SETUP drives the selects with the
//                write enable low, WRITE raises the write enable with the
//                selects unchanged. HALT parks the sequencer until resume.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                in_valid/in_ready/in_instr - instruction handshake
//                resume                   - leave the HALTED state
//                write_enable, mux_sel, input_data, dst_sel, a_sel, b_sel,
//                op_sel                   - datapath control lines
//                busy, halted, retire     - status
//  Config      : DP_SEQ_BACK2BACK_EN - when defined, WRITE may issue the next
//                LOAD/ALU directly into SETUP (one write per 2 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer
    import dp_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               resume,
    output logic               write_enable,
    output logic               mux_sel,
    output logic [7:0]         input_data,
    output logic [3:0]         dst_sel,
    output logic [3:0]         a_sel,
    output logic [3:0]         b_sel,
    output logic [3:0]         op_sel,
    output logic               busy,
    output logic               halted,
    output logic               retire
);

    localparam logic [1:0] c_IDLE   = ST_IDLE;
    localparam logic [1:0] c_SETUP  = ST_SETUP;
    localparam logic [1:0] c_WRITE  = ST_WRITE;
    localparam logic [1:0] c_HALTED = ST_HALTED;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_full;
    logic               w_empty;
    logic [INSTR_W-1:0] w_head;
    logic [1:0]         w_head_kind;
    logic               w_head_exec;
    logic               w_push;
    logic               w_pop;
    logic               w_latch;
    logic               w_retire_nxt;

    logic               r_we;
    logic               r_mux_sel;
    logic [7:0]         r_input_data;
    logic [3:0]         r_dst_sel;
    logic [3:0]         r_a_sel;
    logic [3:0]         r_b_sel;
    logic [3:0]         r_op_sel;
    logic               r_retire;

    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready;

    dp_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_instr),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_head_kind = w_head[KIND_MSB:KIND_LSB];
    assign w_head_exec = !w_empty && is_write_kind(w_head_kind);

    // Next state, pop and latch decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_latch      = 1'b0;
        w_retire_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_exec) begin
                        w_latch     = 1'b1;
                        w_state_nxt = c_SETUP;
                    end else if (w_head_kind == KIND_HALT) begin
                        w_retire_nxt = 1'b1;
                        w_state_nxt  = c_HALTED;
                    end else begin
                        // NOP retires without leaving IDLE
                        w_retire_nxt = 1'b1;
                    end
                end
            end
            c_SETUP: begin
                // Retire is registered so it lands in the WRITE cycle
                w_retire_nxt = 1'b1;
                w_state_nxt  = c_WRITE;
            end
            c_WRITE: begin
`ifdef DP_SEQ_BACK2BACK_EN
                if (w_head_exec) begin
                    w_pop       = 1'b1;
                    w_latch     = 1'b1;
                    w_state_nxt = c_SETUP;
                end else begin
                    w_state_nxt = c_IDLE;
                end
`else
                w_state_nxt = c_IDLE;
`endif
            end
            c_HALTED: begin
                if (resume) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_we         <= 1'b0;
            r_retire     <= 1'b0;
            r_mux_sel    <= 1'b0;
            r_input_data <= '0;
            r_dst_sel    <= '0;
            r_a_sel      <= '0;
            r_b_sel      <= '0;
            r_op_sel     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_we     <= (w_state_nxt == c_WRITE);
            r_retire <= w_retire_nxt;
            // Selects move only when an instruction enters SETUP; fields not
            // used by the instruction keep their previous values.
            if (w_latch) begin
                r_dst_sel <= w_head[DST_MSB:DST_LSB];
                if (w_head_kind == KIND_LOAD) begin
                    r_mux_sel    <= 1'b1;
                    r_input_data <= w_head[IMM_MSB:IMM_LSB];
                end else begin
                    r_mux_sel <= 1'b0;
                    r_a_sel   <= w_head[A_MSB:A_LSB];
                    r_b_sel   <= w_head[B_MSB:B_LSB];
                    r_op_sel  <= w_head[OP_MSB:OP_LSB];
                end
            end
        end
    end

    assign write_enable = r_we;
    assign mux_sel      = r_mux_sel;
    assign input_data   = r_input_data;
    assign dst_sel      = r_dst_sel;
    assign a_sel        = r_a_sel;
    assign b_sel        = r_b_sel;
    assign op_sel       = r_op_sel;
    assign retire       = r_retire;
    // Status flags decode only registered state (FSM and FIFO count)
    assign busy         = (r_state != c_IDLE) || !w_empty;
    assign halted       = (r_state == c_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_sequencer
//  Description : Self-checking bench for datapath_sequencer. Directed
//                timing scenarios plus a randomized run; an instruction-level
//                reference model (queue of accepted words and the expected
//                select state) checks every retirement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [21:0] in_instr = '0;
    logic        resume = 1'b0;
    logic        in_ready;
    logic        write_enable;
    logic        mux_sel;
    logic [7:0]  input_data;
    logic [3:0]  dst_sel;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic [3:0]  op_sel;
    logic        busy;
    logic        halted;
    logic        retire;

    always #5 clk = ~clk;

    datapath_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .resume       (resume),
        .write_enable (write_enable),
        .mux_sel      (mux_sel),
        .input_data   (input_data),
        .dst_sel      (dst_sel),
        .a_sel        (a_sel),
        .b_sel        (b_sel),
        .op_sel       (op_sel),
        .busy         (busy),
        .halted       (halted),
        .retire       (retire)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] mk_load(input logic [3:0] dst, input logic [7:0] imm);
        return {2'b01, dst, 8'h00, imm};
    endfunction

    function automatic logic [21:0] mk_alu(input logic [3:0] dst, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] op);
        return {2'b10, dst, a, b, op, 4'h0};
    endfunction

    function automatic logic [21:0] rnd_instr();
        logic [21:0] w;
        int          r;
        w = 22'($urandom);
        r = int'($urandom_range(0, 99));
        if (r < 20)      w[21:20] = 2'b00;
        else if (r < 55) w[21:20] = 2'b01;
        else if (r < 90) w[21:20] = 2'b10;
        else             w[21:20] = 2'b11;
        return w;
    endfunction

    wire [24:0] sel_now = {mux_sel, input_data, dst_sel, a_sel, b_sel, op_sel};

    // ---------------- instruction-level reference model ----------------
    logic [21:0] q[$];
    logic [24:0] m_sel = '0;
    logic [24:0] prev_sel = '0;
    logic        mon_en = 1'b0;

    initial begin
        logic [21:0] ins;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("we_implies_retire", {31'd0, write_enable & ~retire}, 32'd0);
                if (write_enable) check("sel_stable_setup_write", 32'(sel_now), 32'(prev_sel));
                if (retire) begin
                    check("retire_has_instr", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        ins = q.pop_front();
                        case (ins[21:20])
                            2'b00: begin
                                check("nop_no_write", 32'(write_enable), 32'd0);
                                check("nop_not_halted", 32'(halted), 32'd0);
                            end
                            2'b11: begin
                                check("halt_entry", 32'(halted), 32'd1);
                                check("halt_no_write", 32'(write_enable), 32'd0);
                            end
                            default: begin
                                m_sel[15:12] = ins[19:16];
                                if (ins[21:20] == 2'b01) begin
                                    m_sel[24]    = 1'b1;
                                    m_sel[23:16] = ins[7:0];
                                end else begin
                                    m_sel[24]   = 1'b0;
                                    m_sel[11:0] = ins[15:4];
                                end
                                check("wr_enable", 32'(write_enable), 32'd1);
                                check("wr_selects", 32'(sel_now), 32'(m_sel));
                                check("wr_not_halted", 32'(halted), 32'd0);
                            end
                        endcase
                    end
                end
                prev_sel = sel_now;
                if (rst) begin
                    q.delete();
                    m_sel = '0;
                end else if (in_valid && in_ready) begin
                    q.push_back(in_instr);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int          n;
        int          acc;
        int          wecnt;
        logic [9:0]  pat;
        logic [19:0] seq;
        logic [9:0]  exp_pat;

        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_selects", 32'(sel_now), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // LOAD latency: push at edge 0, write observed after edge 2
        in_valid = 1'b1;
        in_instr = mk_load(4'd3, 8'hA5);
        tick();
        in_valid = 1'b0;
        tick();
        check("ld_setup_we_low", 32'(write_enable), 32'd0);
        check("ld_setup_busy", 32'(busy), 32'd1);
        tick();
        check("ld_we", 32'(write_enable), 32'd1);
        check("ld_mux_dst_data", {19'd0, mux_sel, dst_sel, input_data}, {19'd0, 1'b1, 4'd3, 8'hA5});
        check("ld_retire", 32'(retire), 32'd1);
        tick();
        check("ld_we_drop", 32'(write_enable), 32'd0);

        // ALU: selects stable across SETUP and WRITE, immediate kept
        in_valid = 1'b1;
        in_instr = mk_alu(4'd2, 4'd3, 4'd4, 4'd5);
        tick();
        in_valid = 1'b0;
        tick();
        check("alu_setup", {14'd0, write_enable, mux_sel, dst_sel, a_sel, b_sel, op_sel},
              {14'd0, 1'b0, 1'b0, 4'd2, 4'd3, 4'd4, 4'd5});
        tick();
        check("alu_write", {14'd0, write_enable, mux_sel, dst_sel, a_sel, b_sel, op_sel},
              {14'd0, 1'b1, 1'b0, 4'd2, 4'd3, 4'd4, 4'd5});
        check("alu_data_kept", 32'(input_data), 32'h0A5);
        tick();
        check("alu_we_one_cycle", 32'(write_enable), 32'd0);

        // HALT then LOAD: no write while halted, write 3 cycles after resume
        in_valid = 1'b1;
        in_instr = 22'h30_0000;
        tick();
        in_instr = mk_load(4'd1, 8'h3C);
        tick();
        in_valid = 1'b0;
        wecnt = 0;
        repeat (6) begin
            tick();
            wecnt += int'(write_enable);
        end
        check("halt_blocks_write", 32'(wecnt), 32'd0);
        check("halt_held", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n = 1;
        while (!write_enable && n < 10) begin
            tick();
            n++;
        end
        check("resume_to_write", 32'(n), 32'd3);
        check("resume_write_dst", 32'(dst_sel), 32'd1);
        repeat (2) tick();

        // FIFO full: stall behind HALT, hold valid with LOAD dst 0..4
        in_valid = 1'b1;
        in_instr = 22'h30_0000;
        tick();
        in_valid = 1'b0;
        tick();
        check("full_halted", 32'(halted), 32'd1);
        acc = 0;
        n   = 0;
        while (acc < 4 && n < 20) begin
            in_valid = 1'b1;
            in_instr = mk_load(4'(acc), 8'($urandom));
            if (in_ready) acc++;
            tick();
            n++;
        end
        in_instr = mk_load(4'd4, 8'($urandom));
        check("full_accepted", 32'(acc), 32'd4);
        check("full_ready_low", 32'(in_ready), 32'd0);
        repeat (2) tick();
        check("full_ready_hold", 32'(in_ready), 32'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("full_ready_idle", 32'(in_ready), 32'd0);
        tick();
        check("full_ready_after_pop", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n   = 0;
        acc = 0;
        seq = '0;
        while ((busy || acc < 5) && n < 40) begin
            if (write_enable) begin
                seq = {seq[15:0], dst_sel};
                acc++;
            end
            tick();
            n++;
        end
        check("full_write_order", 32'(seq), 32'h01234);
        repeat (2) tick();

        // NOP stream: one retire per cycle, never a write
        pat   = '0;
        wecnt = 0;
        for (int t = 0; t < 10; t++) begin
            in_valid = (t < 6);
            in_instr = 22'h00_0000 | 22'($urandom_range(0, 65535));
            tick();
            pat[t] = retire;
            wecnt += int'(write_enable);
        end
        in_valid = 1'b0;
        check("nop_retire_pattern", 32'(pat), 32'h07E);
        check("nop_no_writes", 32'(wecnt), 32'd0);

        // Two LOADs back to back: write spacing
        pat = '0;
        for (int t = 0; t < 10; t++) begin
            in_valid = (t < 2);
            in_instr = mk_load(4'(t + 8), 8'(t + 16));
            tick();
            pat[t] = write_enable;
        end
        in_valid = 1'b0;
`ifdef DP_SEQ_BACK2BACK_EN
        exp_pat = 10'b00_0001_0100;
`else
        exp_pat = 10'b00_0010_0100;
`endif
        check("throughput_pattern", 32'(pat), 32'(exp_pat));
        repeat (2) tick();

        // Reset during WRITE with more instructions queued
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            in_instr = mk_load(4'(t + 5), 8'h5A);
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (!write_enable && n < 10) begin
            tick();
            n++;
        end
        check("rstw_in_write", 32'(write_enable), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_we_low", 32'(write_enable), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_in_ready", 32'(in_ready), 32'd1);
        check("rstw_selects", 32'(sel_now), 32'd0);
        wecnt = 0;
        repeat (6) begin
            tick();
            wecnt += int'(write_enable) + int'(retire);
        end
        check("rstw_discarded", 32'(wecnt), 32'd0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 99) < 55);
            in_instr = rnd_instr();
            resume   = ($urandom_range(0, 99) < 25);
            tick();
        end
        in_valid = 1'b0;
        resume   = 1'b0;
        n = 0;
        while ((busy || halted) && n < 300) begin
            resume = halted;
            tick();
            n++;
        end
        resume = 1'b0;
        repeat (2) tick();
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_model_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
